partial_sum_accumulator: RTL
============================

Name: partial_sum_accumulator

Overview:
- Sits directly downstream of the 16-lane pipelined adder tree.
- Each adder-tree output is one signed 16-bit partial dot product. This block accumulates NUM_PARTIALS consecutive partials into a wide signed accumulator.
- It then applies optional ReLU, saturates the result to OUT_DATA_WIDTH, and presents it on a valid/ready output through a 2-entry result buffer.
- The upstream tree has no backpressure. Results that cannot be buffered are dropped and flagged.

Parameters:
- IN_DATA_WIDTH, 16: width of the signed partial sum from the adder tree.
- ACC_WIDTH, 24: internal signed accumulator width. Must be at least IN_DATA_WIDTH + clog2(NUM_PARTIALS).
- OUT_DATA_WIDTH, 16: width of the signed saturated result.
- NUM_PARTIALS, 4: partials per result. Range 1..256.
- RELU_EN, 1: 1 clamps negative results to 0 before saturation; 0 passes them through.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- s_tdata  input  IN_DATA_WIDTH  signed partial sum
- s_tvalid  input  1  partial valid; no ready, accepted every cycle it is high
- m_tdata  output  OUT_DATA_WIDTH  signed final result
- m_tvalid  output  1  result valid
- m_tready  input  1  downstream accepts result
- beat_count  output  8  partials accumulated toward the current result
- overflow  output  1  sticky: a completed result was dropped because the buffer was full

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. On assertion, immediately:
  - m_tvalid=0, m_tdata=0
  - beat_count=0, overflow=0
  - accumulator=0, buffer emptied
- Reset mid-accumulation discards the partial result. The next beat after release is beat 0.
- Sign handling: s_tdata is sign-extended to ACC_WIDTH.
- On each cycle with s_tvalid=1:
  - beat_count==0: acc <= sext(s_tdata) (no stale carry-in).
  - beat_count==NUM_PARTIALS-1: final = acc + sext(s_tdata); acc is not updated; beat_count <= 0; final is pushed into the buffer.
  - Otherwise: acc <= acc + sext(s_tdata); beat_count increments.
  - NUM_PARTIALS=1: every valid beat is final; final = sext(s_tdata).
- s_tvalid=0 cycles hold acc and beat_count. Gaps between beats are allowed.
- Post-processing (combinational before the push):
  - If RELU_EN and final<0, value=0.
  - Saturate to [-2^(OUT_DATA_WIDTH-1), 2^(OUT_DATA_WIDTH-1)-1].
- Latency: the result is visible on m_tdata with m_tvalid=1 in the cycle after the final beat's rising edge, when the buffer was empty.
- Output buffer: 2-entry FIFO, in-order.
  - m_tdata/m_tvalid come from the head entry.
  - Pop on m_tvalid&&m_tready.
  - m_tdata holds steady while m_tvalid=1 and m_tready=0.
- Push while the buffer is full:
  - With a pop the same cycle: push succeeds (pop frees the slot first); no overflow.
  - Without a pop: the result is dropped, overflow <= 1, and buffer contents are unchanged.
- overflow clears only on rst.
- Accumulator wrap cannot occur within parameter limits. No modular arithmetic is relied on.

Test Plan:
- NUM_PARTIALS=4, RELU_EN=0, m_tready=1. Beats 100, -20, 7, 13 back-to-back -> one cycle after beat 4, m_tdata=100, m_tvalid=1 for 1 cycle. beat_count sequence 0,1,2,3,0.
- Saturation: 4 beats of 0x7FFF -> sum 131068, m_tdata=0x7FFF. Then 4 beats of 0x8000 with RELU_EN=0 -> m_tdata=0x8000. With RELU_EN=1, beats -5,-5,-5,-5 -> m_tdata=0.
- Gapped input: beats 1,2,3,4 with s_tvalid low 3 cycles between each -> single result 10. No result emitted early.
- Backpressure: m_tready=0, three back-to-back results (sums 10, 20, 30):
  - Buffer holds 10 then 20; 30 is dropped; overflow=1.
  - Raise m_tready -> outputs 10 then 20, then m_tvalid=0.
  - Repeat with m_tready pulsed in the cycle the third result completes -> output sequence 10, 20, 30; overflow stays 0.
- Reset mid-operation: after beats 50, 60 (beat_count=2), assert rst asynchronously between edges -> outputs clear immediately. After release, beats 1,1,1,1 -> m_tdata=4 (no 110 carried over).
- NUM_PARTIALS=1: stream -3, 9 -> RELU_EN=1 gives outputs 0, 9 on consecutive cycles, each one cycle after its input.

Source files
------------

// File: rtl/partial_sum_accumulator.sv
// partial_sum_accumulator
//   Accumulates NUM_PARTIALS consecutive signed partial dot products from the
//   adder tree. It then applies optional ReLU and saturates the result to
//   OUT_DATA_WIDTH. Finished results are queued in a 2-entry in-order buffer
//   with a valid/ready output. Results that arrive while the buffer is full
//   with no pop are dropped, and the sticky overflow flag is set.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   s_tdata    signed partial sum (IN_DATA_WIDTH)
//   s_tvalid   partial valid, accepted every cycle it is high (no ready)
//   m_tdata    signed saturated result (OUT_DATA_WIDTH), head of buffer
//   m_tvalid   result valid
//   m_tready   downstream accepts result
//   beat_count partials accumulated toward the current result
//   overflow   sticky, a completed result was dropped
module partial_sum_accumulator #(
   parameter int unsigned IN_DATA_WIDTH  = 16,
   parameter int unsigned ACC_WIDTH      = 24,
   parameter int unsigned OUT_DATA_WIDTH = 16,
   parameter int unsigned NUM_PARTIALS   = 4,
   parameter bit          RELU_EN        = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [IN_DATA_WIDTH-1:0]  s_tdata,
   input  logic                      s_tvalid,
   output logic [OUT_DATA_WIDTH-1:0] m_tdata,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic [7:0]                beat_count,
   output logic                      overflow
);

   localparam int unsigned EXT_BITS = ACC_WIDTH - IN_DATA_WIDTH;
   localparam int unsigned PAD_BITS = ACC_WIDTH - OUT_DATA_WIDTH + 1;
   localparam logic [7:0]  LAST_BEAT = 8'(NUM_PARTIALS - 1);

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{PAD_BITS{1'b0}}, {(OUT_DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{PAD_BITS{1'b1}}, {(OUT_DATA_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] in_ext;
   logic signed [ACC_WIDTH-1:0] base;
   logic signed [ACC_WIDTH-1:0] final_sum;
   logic signed [ACC_WIDTH-1:0] relu_val;
   logic [OUT_DATA_WIDTH-1:0]   sat_val;
   logic                        last_beat;

   logic [OUT_DATA_WIDTH-1:0]   mem [2];
   logic                        rd_ptr;
   logic                        wr_ptr;
   logic [1:0]                  count;
   logic                        push;
   logic                        pop;
   logic                        push_ok;

   // Beat 0 starts from zero instead of acc, so no stale carry-in. This also
   // makes NUM_PARTIALS=1 fall out naturally (final = sext(s_tdata)).
   always_comb begin
      in_ext    = {{EXT_BITS{s_tdata[IN_DATA_WIDTH-1]}}, s_tdata};
      base      = (beat_count == 8'd0) ? '0 : acc;
      final_sum = base + in_ext;
      relu_val  = (RELU_EN && (final_sum < 0)) ? '0 : final_sum;
      if (relu_val > SAT_MAX) begin
         sat_val = SAT_MAX[OUT_DATA_WIDTH-1:0];
      end else if (relu_val < SAT_MIN) begin
         sat_val = SAT_MIN[OUT_DATA_WIDTH-1:0];
      end else begin
         sat_val = relu_val[OUT_DATA_WIDTH-1:0];
      end
      last_beat = (beat_count == LAST_BEAT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         beat_count <= '0;
      end else if (s_tvalid) begin
         if (last_beat) begin
            beat_count <= '0;
         end else begin
            acc        <= final_sum;
            beat_count <= beat_count + 8'd1;
         end
      end
   end

   // A pop in the same cycle frees a slot, so a push into a full buffer
   // succeeds in that case. When the buffer is full, wr_ptr equals rd_ptr,
   // and the new entry overwrites the slot being popped.
   always_comb begin
      m_tvalid = (count != 2'd0);
      m_tdata  = m_tvalid ? mem[rd_ptr] : '0;
      pop      = m_tvalid && m_tready;
      push     = s_tvalid && last_beat;
      push_ok  = push && ((count != 2'd2) || pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= sat_val;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push_ok) - 2'(pop);
         if (push && !push_ok) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule
